// File: rtl/bnn_weight_loader.sv
// Nibble-stream deserialiser that loads weight/threshold records into the 8-8-4 BNN core.
// Optional frame checksum nibble enabled by defining BNN_LOADER_CHECKSUM_EN.
module bnn_weight_loader #(
    parameter int NUM_NEURONS = 20,
    parameter int ADDR_W      = 5,
    parameter int W_BITS      = 8,
    parameter int T_BITS      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ena,
    input  logic              frame_start,
    input  logic [3:0]        nib_in,
    input  logic              nib_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [W_BITS-1:0] wr_weight,
    output logic [T_BITS-1:0] wr_thr,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef BNN_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_W_LO, S_W_HI, S_THR, S_CHK} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_W_LO, S_W_HI, S_THR} state_t;
`endif

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_NEURONS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [3:0]          lo_q, lo_d;
    logic [3:0]          hi_q, hi_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [W_BITS-1:0]   weight_q, weight_d;
    logic [T_BITS-1:0]   thr_q, thr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
`ifdef BNN_LOADER_CHECKSUM_EN
    logic [3:0]          xor_q, xor_d;
`endif

    always_comb begin
        // NOTE: every _d starts as its _q so no path leaves a signal unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        wr_en_d  = wr_en_q;
        addr_d   = addr_q;
        weight_d = weight_q;
        thr_d    = thr_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
`ifdef BNN_LOADER_CHECKSUM_EN
        xor_d    = xor_q;
`endif
        // With ena low everything holds, including a pending write strobe.
        if (ena) begin
            wr_en_d = 1'b0;
            if (frame_start) begin
                state_d = S_W_LO;
                cnt_d   = '0;
                lo_d    = '0;
                hi_d    = '0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                err_d   = 1'b0;
`ifdef BNN_LOADER_CHECKSUM_EN
                xor_d   = '0;
`endif
            end else if (nib_valid) begin
`ifdef BNN_LOADER_CHECKSUM_EN
                if (state_q != S_IDLE && state_q != S_CHK) xor_d = xor_q ^ nib_in;
`endif
                case (state_q)
                    S_IDLE: err_d = 1'b1;
                    S_W_LO: begin
                        lo_d    = nib_in;
                        state_d = S_W_HI;
                    end
                    S_W_HI: begin
                        hi_d    = nib_in;
                        state_d = S_THR;
                    end
                    S_THR: begin
                        wr_en_d  = 1'b1;
                        addr_d   = cnt_q;
                        weight_d = {hi_q, lo_q};
                        thr_d    = nib_in;
                        if (cnt_q == LAST) begin
`ifdef BNN_LOADER_CHECKSUM_EN
                            state_d = S_CHK;
`else
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
`endif
                        end else begin
                            cnt_d   = cnt_q + ADDR_W'(1);
                            state_d = S_W_LO;
                        end
                    end
`ifdef BNN_LOADER_CHECKSUM_EN
                    S_CHK: begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        if (nib_in == xor_q) done_d = 1'b1;
                        else                 err_d  = 1'b1;
                    end
`endif
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            weight_q <= '0;
            thr_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef BNN_LOADER_CHECKSUM_EN
            xor_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            wr_en_q  <= wr_en_d;
            addr_q   <= addr_d;
            weight_q <= weight_d;
            thr_q    <= thr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef BNN_LOADER_CHECKSUM_EN
            xor_q    <= xor_d;
`endif
        end
    end

    assign wr_en     = wr_en_q & ena;
    assign wr_addr   = addr_q;
    assign wr_weight = weight_q;
    assign wr_thr    = thr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
